// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
//   state_t   : arbiter FSM states
//   GNT_IF/D  : grant identifiers (fetch path / load-store path)
//   CNT_W     : width of the wait-state counter (WAIT_CYCLES range 0..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the memory.
//   fetch  : if_req, if_addr -> if_ack, if_rdata
//   data   : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//   memory : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   status : busy, dbg_state (current arbiter state)
//
// Handshake: a requester raises req with a stable payload and holds it until
// the matching ack, which is a single-cycle pulse. The requester drops req in
// the cycle after ack; otherwise it is granted again. Payload changes after
// the grant are ignored.
//
// Modports: slave = arbiter side, master = CPU/memory side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  state_t            dbg_state;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state
  );

endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// wait_counter: 4-bit loadable down-counter for memory wait states.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   zero     : count is zero
module wait_counter
  import mem_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch path and the load/store path.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if slave modport (requesters, memory, status)
// Parameters: ADDR_W, DATA_W, WAIT_CYCLES (extra memory latency, 0..15).
//
// Flow: IDLE grants (alternating priority on conflict) and latches the
// payload; ACCESS drives mem_en for one cycle; WAIT spends WAIT_CYCLES cycles;
// read data is captured on the edge leaving the last ACCESS/WAIT cycle; RESP
// pulses the granted ack. All outputs come from registers or the state.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  // ACCESS already counts as the first memory cycle, so WAIT runs for
  // WAIT_CYCLES cycles when the counter starts at WAIT_CYCLES-1.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic              last_gnt_q;
  logic              gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic grant;
  logic gnt_sel;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic capture;

  wait_counter u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    gnt_sel  = GNT_IF;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          if (bus.if_req && bus.d_req) begin
            gnt_sel = (last_gnt_q == GNT_IF) ? GNT_D : GNT_IF;
          end else begin
            gnt_sel = bus.d_req ? GNT_D : GNT_IF;
          end
        end
      end
      ACCESS: begin
        if (WAIT_CYCLES > 0) begin
          cnt_load = 1'b1;
          state_d  = WAIT;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_gnt_q <= GNT_IF;
      gnt_q      <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant) begin
        gnt_q <= gnt_sel;
        if (gnt_sel == GNT_D) begin
          addr_q  <= bus.d_addr;
          we_q    <= bus.d_we;
          wdata_q <= bus.d_wdata;
        end else begin
          // Fetches are read-only; mem_wdata keeps its last value.
          addr_q <= bus.if_addr;
          we_q   <= 1'b0;
        end
      end
      if (capture && !we_q) begin
        if (gnt_q == GNT_D) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= bus.mem_rdata;
        end
      end
      if (state_q == RESP) begin
        last_gnt_q <= gnt_q;
      end
    end
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = (state_q == RESP) && (gnt_q == GNT_IF);
  assign bus.d_ack     = (state_q == RESP) && (gnt_q == GNT_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (WAIT_CYCLES=2 as index 0,
// WAIT_CYCLES=0 as index 1) share one memory model. Stimulus pushes the
// expected memory accesses and acks into queues; monitors pop and compare.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a.slave));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b.slave));

  function automatic int wait_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // ---------------- drive / snapshot arrays ----------------
  logic          drv_if_req [2] = '{default: 1'b0};
  logic          drv_d_req  [2] = '{default: 1'b0};
  logic          drv_d_we   [2] = '{default: 1'b0};
  logic [AW-1:0] drv_if_addr[2] = '{default: '0};
  logic [AW-1:0] drv_d_addr [2] = '{default: '0};
  logic [DW-1:0] drv_d_wdata[2] = '{default: '0};
  logic [DW-1:0] mrd        [2];

  logic          s_if_ack[2], s_d_ack[2], s_mem_en[2], s_mem_we[2], s_busy[2];
  logic [AW-1:0] s_mem_addr[2];
  logic [DW-1:0] s_mem_wdata[2], s_if_rdata[2], s_d_rdata[2];
  state_t        s_state[2];

  assign bus_a.if_req = drv_if_req[0];   assign bus_b.if_req = drv_if_req[1];
  assign bus_a.if_addr = drv_if_addr[0]; assign bus_b.if_addr = drv_if_addr[1];
  assign bus_a.d_req = drv_d_req[0];     assign bus_b.d_req = drv_d_req[1];
  assign bus_a.d_we = drv_d_we[0];       assign bus_b.d_we = drv_d_we[1];
  assign bus_a.d_addr = drv_d_addr[0];   assign bus_b.d_addr = drv_d_addr[1];
  assign bus_a.d_wdata = drv_d_wdata[0]; assign bus_b.d_wdata = drv_d_wdata[1];
  assign bus_a.mem_rdata = mrd[0];       assign bus_b.mem_rdata = mrd[1];

  assign s_if_ack[0] = bus_a.if_ack;       assign s_if_ack[1] = bus_b.if_ack;
  assign s_d_ack[0] = bus_a.d_ack;         assign s_d_ack[1] = bus_b.d_ack;
  assign s_mem_en[0] = bus_a.mem_en;       assign s_mem_en[1] = bus_b.mem_en;
  assign s_mem_we[0] = bus_a.mem_we;       assign s_mem_we[1] = bus_b.mem_we;
  assign s_busy[0] = bus_a.busy;           assign s_busy[1] = bus_b.busy;
  assign s_mem_addr[0] = bus_a.mem_addr;   assign s_mem_addr[1] = bus_b.mem_addr;
  assign s_mem_wdata[0] = bus_a.mem_wdata; assign s_mem_wdata[1] = bus_b.mem_wdata;
  assign s_if_rdata[0] = bus_a.if_rdata;   assign s_if_rdata[1] = bus_b.if_rdata;
  assign s_d_rdata[0] = bus_a.d_rdata;     assign s_d_rdata[1] = bus_b.d_rdata;
  assign s_state[0] = bus_a.dbg_state;     assign s_state[1] = bus_b.dbg_state;

  // ---------------- memory model ----------------
  // Read data is presented only in the (WAIT+1)th cycle counting the mem_en
  // cycle as the first; any other cycle shows a poison word.
  logic [DW-1:0] mem     [128] = '{default: '0};
  logic          wr_flag [128] = '{default: 1'b0};
  int            age     [2]   = '{default: 0};

  function automatic logic [DW-1:0] preload(logic [AW-1:0] a);
    case (a)
      32'h0000_0040: return 32'h2002_0005;
      32'h0000_0080: return 32'h8080_8080;
      32'h0000_0008: return 32'h0000_0E08;
      default:       return ~a;
    endcase
  endfunction

  function automatic logic [DW-1:0] rd(logic [AW-1:0] a);
    return wr_flag[a[8:2]] ? mem[a[8:2]] : preload(a);
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (s_mem_en[d] && s_mem_we[d]) begin
        mem[s_mem_addr[d][8:2]]     <= s_mem_wdata[d];
        wr_flag[s_mem_addr[d][8:2]] <= 1'b1;
      end
      if (s_mem_en[d]) age[d] <= 1;
      else if (age[d] != 0 && age[d] <= wait_of(d)) age[d] <= age[d] + 1;
      else age[d] <= 0;
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      mrd[d] = 32'hBAD0_BAD0;
      if ((wait_of(d) == 0) ? s_mem_en[d] : (age[d] == wait_of(d)))
        mrd[d] = rd(s_mem_addr[d]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int grant_cyc = 0;

  // ack entry: {dut, is_data, rdata[31:0], cycle[31:0]}
  logic [65:0] ack_q[$];
  // mem entry: {dut, we, addr[31:0], wdata[31:0], cycle[31:0]}
  logic [97:0] mem_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic [65:0] ea;
    logic [97:0] em;
    for (int d = 0; d < 2; d++) begin
      if (s_if_ack[d] || s_d_ack[d]) begin
        check("ack_onehot", 64'(s_if_ack[d] & s_d_ack[d]), 64'(0));
        if (ack_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: dut%0d acked at cycle %0d, expected no ack", d, cyc);
        end else begin
          ea = ack_q.pop_front();
          check("ack_dut", 64'(d), 64'(ea[65]));
          check("ack_id", 64'(s_d_ack[d]), 64'(ea[64]));
          check("ack_rdata", 64'(s_d_ack[d] ? s_d_rdata[d] : s_if_rdata[d]), 64'(ea[63:32]));
          check("ack_cycle", 64'(cyc), 64'(ea[31:0]));
        end
      end
      if (s_mem_en[d]) begin
        check("busy_in_access", 64'(s_busy[d]), 64'(1));
        if (mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_mem_en: dut%0d at cycle %0d, expected none", d, cyc);
        end else begin
          em = mem_q.pop_front();
          check("mem_dut", 64'(d), 64'(em[97]));
          check("mem_we", 64'(s_mem_we[d]), 64'(em[96]));
          check("mem_addr", 64'(s_mem_addr[d]), 64'(em[95:64]));
          if (em[96]) check("mem_wdata", 64'(s_mem_wdata[d]), 64'(em[63:32]));
          check("mem_cycle", 64'(cyc), 64'(em[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      check("rst_ctrl", 64'({s_if_ack[d], s_d_ack[d], s_mem_en[d], s_mem_we[d], s_busy[d]}), 64'(0));
      check("rst_mem_addr", 64'(s_mem_addr[d]), 64'(0));
      check("rst_mem_wdata", 64'(s_mem_wdata[d]), 64'(0));
      check("rst_if_rdata", 64'(s_if_rdata[d]), 64'(0));
      check("rst_d_rdata", 64'(s_d_rdata[d]), 64'(0));
      check("rst_state", 64'(s_state[d]), 64'(IDLE));
    end
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_state();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Called at a negedge while the DUT is idle: grant happens on the next edge.
  task automatic start_txn(int d, bit is_data, bit we, logic [AW-1:0] addr,
                           logic [DW-1:0] wdata, logic [DW-1:0] exp, bit push_ack);
    int g;
    g = cyc + 1;
    if (is_data) begin
      drv_d_req[d] = 1'b1; drv_d_we[d] = we; drv_d_addr[d] = addr; drv_d_wdata[d] = wdata;
    end else begin
      drv_if_req[d] = 1'b1; drv_if_addr[d] = addr;
    end
    mem_q.push_back({d[0], we, addr, wdata, 32'(g)});
    if (push_ack) ack_q.push_back({d[0], is_data, exp, 32'(g + 1 + wait_of(d))});
    grant_cyc = g;
  endtask

  // Waits for the ack, drops the request, returns at the following negedge.
  task automatic finish_txn(int d, bit chg, logic [AW-1:0] alt, logic [AW-1:0] orig);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (chg && cyc == grant_cyc) drv_if_addr[d] = alt;
      if (chg && cyc == grant_cyc + 1)
        check("addr_hold_wait", 64'(s_mem_addr[d]), 64'(orig));
      if (s_if_ack[d] || s_d_ack[d]) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: dut%0d no ack within 30 cycles, expected one", d);
    end
    drv_if_req[d] = 1'b0;
    drv_d_req[d]  = 1'b0;
    @(negedge clock);
    check("ack_pulse_width", 64'({s_if_ack[d], s_d_ack[d]}), 64'(0));
  endtask

  task automatic txn(int d, bit is_data, bit we, logic [AW-1:0] addr,
                     logic [DW-1:0] wdata, logic [DW-1:0] exp);
    start_txn(d, is_data, we, addr, wdata, exp, 1'b1);
    finish_txn(d, 1'b0, '0, '0);
  endtask

  // Both requesters held high for n reads; grants alternate.
  task automatic conflict(int d, int n, logic [AW-1:0] daddr, logic [DW-1:0] dexp,
                          logic [AW-1:0] iaddr, logic [DW-1:0] iexp, bit first_data);
    int g, per, seen;
    bit isd, a, prev;
    g = cyc + 1;
    per = 3 + wait_of(d);
    drv_d_req[d] = 1'b1; drv_d_we[d] = 1'b0; drv_d_addr[d] = daddr;
    drv_if_req[d] = 1'b1; drv_if_addr[d] = iaddr;
    for (int k = 0; k < n; k++) begin
      isd = first_data ^ k[0];
      mem_q.push_back({d[0], 1'b0, isd ? daddr : iaddr, 32'h0, 32'(g + k * per)});
      ack_q.push_back({d[0], isd, isd ? dexp : iexp, 32'(g + k * per + 1 + wait_of(d))});
    end
    seen = 0;
    prev = 1'b0;
    for (int i = 0; i < n * per + 10; i++) begin
      @(negedge clock);
      a = s_if_ack[d] | s_d_ack[d];
      if (prev) check("conflict_ack_width", 64'(a), 64'(0));
      if (a) begin
        seen++;
        if (seen == n) begin drv_d_req[d] = 1'b0; drv_if_req[d] = 1'b0; end
      end
      prev = a;
      if (seen == n && !a) break;
    end
    check("conflict_ack_count", 64'(seen), 64'(n));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clock);
    check_reset_state();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // WAIT_CYCLES=2 instance
    txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2002_0005);
    check("if_rdata_held", 64'(s_if_rdata[0]), 64'(32'h2002_0005));
    txn(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
    check("d_rdata_after_write", 64'(s_d_rdata[0]), 64'(0));
    txn(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    txn(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF);
    check("d_rdata_kept_by_write", 64'(s_d_rdata[0]), 64'(32'hDEAD_BEEF));
    start_txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2002_0005, 1'b1);
    finish_txn(0, 1'b1, 32'h80, 32'h40);

    do_reset();
    conflict(0, 3, 32'h100, 32'hDEAD_BEEF, 32'h40, 32'h2002_0005, 1'b1);

    // Reset during WAIT of a fetch: no ack, then a fresh grant of the held req.
    start_txn(0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_state", 64'(s_state[0]), 64'(WAIT));
    do_reset();
    start_txn(0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h8080_8080, 1'b1);
    finish_txn(0, 1'b0, '0, '0);

    // WAIT_CYCLES=0 instance
    txn(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0000_0E08);
    txn(1, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h0000_0E08);
    txn(1, 1'b1, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D);
    txn(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
    conflict(1, 2, 32'h8, 32'h0000_0E08, 32'h80, 32'h8080_8080, 1'b1);

    repeat (4) @(negedge clock);
    check("ack_q_drained", 64'(ack_q.size()), 64'(0));
    check("mem_q_drained", 64'(mem_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between the instruction-fetch path and the load/store path of the multicycle CPU (`op_aut` datapath under `fsm` control). Each requester holds a request until acknowledged. The arbiter resolves conflicts by alternating priority, sequences the memory through a configurable wait-state count, and returns read data with a one-cycle acknowledge pulse.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_CYCLES`, 2, extra memory latency cycles after the enable cycle (0..15)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request (read-only)
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle fetch completion pulse
- `if_rdata`  out  DATA_W  fetched word, valid while `if_ack`=1, held afterwards
- `d_req`  in  1  data request
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_W  load result, valid while `d_ack`=1, held afterwards
- `mem_en`  out  1  memory enable, one cycle per access
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  registered access address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: no request -> stay. One request -> grant it. Both requests -> grant the requester not granted last (`last_gnt`). On grant, latch addr, we (fetch forces 0), wdata and grant id. Go to ACCESS.
- ACCESS: `mem_en`=1, `mem_we`=latched we. Next state is WAIT if `WAIT_CYCLES`>0 (counter loaded with `WAIT_CYCLES`-1), else RESP.
- WAIT: decrement counter. Go to RESP when it reaches 0.
- Leaving the last ACCESS/WAIT cycle: for reads, capture `mem_rdata` into the granted requester's rdata register. Writes leave `d_rdata` unchanged.
- RESP: pulse `if_ack` or `d_ack` for the granted requester, update `last_gnt`, return to IDLE.
- Requests are sampled only in IDLE.
  - Request inputs and payload changing after grant have no effect. The transaction completes and acks regardless.
  - A requester must drop `req` in the cycle after its ack, or it is re-granted.
- Never more than one ack per cycle. Never both acks in the same transaction.

## Timing
- Reset (`reset`=0, any state, including mid-transaction):
  - State -> IDLE.
  - `if_ack`, `d_ack`, `mem_en`, `mem_we`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; wait counter = 0.
  - `last_gnt` = fetch, so the first conflict goes to data.
  - The in-flight transaction is dropped with no ack.
- Latency: request seen in IDLE at edge N -> `mem_en` in cycle N+1 -> ack in cycle N+2+`WAIT_CYCLES`.
- Throughput: one access per 3+`WAIT_CYCLES` cycles, since IDLE is always revisited.
- All outputs are registered or decoded from the state register only. There is no combinational path from a `req` input to any output.
- Memory contract: `mem_rdata` is valid at the edge ending the (`WAIT_CYCLES`+1)th cycle after `mem_en` is sampled.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, ACCESS, WAIT, RESP), grant id constants (GNT_IF=0, GNT_D=1).
- Sub-module `wait_counter`: 4-bit loadable down-counter with `load`, `dec` and `zero` outputs, async active-low reset.
- FSM, grant logic and payload/rdata registers live in `mem_arbiter`.

## Test plan
- Fetch only, `WAIT_CYCLES`=2: `if_req`=1, `if_addr`=0x40, memory returns 0x2002_0005.
  - `mem_en` appears one cycle after the IDLE sample with `mem_addr`=0x40.
  - `if_ack` follows 3 cycles after `mem_en`, with `if_rdata`=0x2002_0005.
  - `d_ack` stays 0 throughout.
- Data write: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF.
  - One cycle with `mem_en`=`mem_we`=1 and those values on `mem_addr`/`mem_wdata`.
  - `d_ack` pulses; `d_rdata` is unchanged.
- Simultaneous `if_req` and `d_req` held high across three transactions out of reset:
  - Grant order is data, fetch, data.
  - Each ack is one cycle wide.
- `WAIT_CYCLES`=0 (separate elaboration): read at 0x8 completes with ack 2 cycles after the IDLE sample.
- Assert `reset`=0 during WAIT of a read:
  - All outputs go to 0 immediately and the state goes to IDLE.
  - No ack follows.
  - After reset release, a pending `if_req` is granted fresh.
- Change `if_addr` from 0x40 to 0x80 during ACCESS: `mem_addr` stays 0x40.
